// File: rtl/fcall_arbiter_if.sv
// Caller-side and function-side handshake bundle for fcall_arbiter.
// slave is the arbiter's view; master is the view of whatever drives callers and hosts the function.
interface fcall_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NARGS = 3,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*NARGS*WIDTH-1:0] req_args;
  logic [NREQ-1:0]             req_done;
  logic [NREQ-1:0]             req_error;
  logic [WIDTH-1:0]            req_result;
  logic [NREQ-1:0]             grant;
  logic                        busy;
  logic                        fn_ready;
  logic [NARGS*WIDTH-1:0]      fn_args;
  logic                        fn_done;
  logic [WIDTH-1:0]            fn_result;

  modport slave (
    input  req_ready, req_args, fn_done, fn_result,
    output req_done, req_error, req_result, grant, busy, fn_ready, fn_args
  );

  modport master (
    output req_ready, req_args, fn_done, fn_result,
    input  req_done, req_error, req_result, grant, busy, fn_ready, fn_args
  );
endinterface

// File: rtl/fcall_arbiter.sv
// Round-robin arbiter sharing one ready/done function instance among NREQ callers,
// with a settle window for stale done and a cycle-budget abort.
//   state  | meaning
//   IDLE   | no owner; picks the next requester from the round-robin pointer
//   WAIT   | fn_ready high, waiting for a fresh fn_done or the timeout
//   RETURN | result/error held for the owner until it drops req_ready
module fcall_arbiter #(
  parameter int NREQ    = 4,
  parameter int NARGS   = 3,
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1023
) (
  input logic           clock,
  input logic           reset_n,
  fcall_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int AW = NARGS * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETURN} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt, own, own_nxt, ptr_inc;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [NREQ-1:0]  grant_r, grant_nxt, done_r, done_nxt, err_r, err_nxt;
  logic [WIDTH-1:0] result_r, result_nxt;
  logic             fn_ready_r, fn_ready_nxt;
  logic [AW-1:0]    fn_args_r, fn_args_nxt;
  logic             win_found;
  logic [PW-1:0]    win_idx, idx;
  logic [AW-1:0]    win_args;
  logic             own_ready;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    win_args  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!win_found && bus.req_ready[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    for (int c = 0; c < NREQ; c++) begin
      if (win_idx == PW'(c)) win_args = bus.req_args[c*AW +: AW];
    end
  end

  assign own_ready = |(bus.req_ready & grant_r);
  assign ptr_inc   = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    own_nxt      = own;
    cnt_nxt      = cnt;
    grant_nxt    = grant_r;
    done_nxt     = done_r;
    err_nxt      = err_r;
    result_nxt   = result_r;
    fn_ready_nxt = fn_ready_r;
    fn_args_nxt  = fn_args_r;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt    = S_WAIT;
          own_nxt      = win_idx;
          grant_nxt    = NREQ'(1) << win_idx;
          fn_args_nxt  = win_args;
          fn_ready_nxt = 1'b1;
          cnt_nxt      = '0;
        end
      end
      S_WAIT: begin
        if (cnt != CW'(TIMEOUT)) cnt_nxt = cnt + CW'(1);
        if (!own_ready) begin
          fn_ready_nxt = 1'b0;
          grant_nxt    = '0;
          ptr_nxt      = ptr_inc;
          state_nxt    = S_IDLE;
        end else if (bus.fn_done && (cnt >= CW'(SETTLE))) begin
          result_nxt   = bus.fn_result;
          done_nxt     = grant_r;
          fn_ready_nxt = 1'b0;
          state_nxt    = S_RETURN;
        end else if (cnt == CW'(TIMEOUT)) begin
          result_nxt   = '0;
          done_nxt     = grant_r;
          err_nxt      = grant_r;
          fn_ready_nxt = 1'b0;
          state_nxt    = S_RETURN;
        end
      end
      S_RETURN: begin
        if (!own_ready) begin
          done_nxt  = '0;
          err_nxt   = '0;
          grant_nxt = '0;
          ptr_nxt   = ptr_inc;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      own        <= '0;
      cnt        <= '0;
      grant_r    <= '0;
      done_r     <= '0;
      err_r      <= '0;
      result_r   <= '0;
      fn_ready_r <= 1'b0;
      fn_args_r  <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      own        <= own_nxt;
      cnt        <= cnt_nxt;
      grant_r    <= grant_nxt;
      done_r     <= done_nxt;
      err_r      <= err_nxt;
      result_r   <= result_nxt;
      fn_ready_r <= fn_ready_nxt;
      fn_args_r  <= fn_args_nxt;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.req_done   = done_r;
  assign bus.req_error  = err_r;
  assign bus.req_result = result_r;
  assign bus.fn_ready   = fn_ready_r;
  assign bus.fn_args    = fn_args_r;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_fcall_arbiter.sv
// Scoreboard bench for fcall_arbiter: callers drive fib' calls into a behavioural
// tail-recursive fib model; a negedge monitor checks every req_done against queued expectations.
module tb_fcall_arbiter;
  localparam int NREQ  = 4;
  localparam int NARGS = 3;
  localparam int WIDTH = 8;
  localparam int AW    = NARGS * WIDTH;

  typedef struct {
    int         c;
    logic [7:0] res;
    bit         err;
    int         lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0]    rdy = '0;
  logic [NREQ*AW-1:0] args_v = '0;
  bit stale_mode = 1'b0;
  bit nodone_mode = 1'b0;

  logic       m_run = 1'b0, m_done = 1'b0;
  logic [7:0] m_a = '0, m_b = '0, m_n = '0;
  int         age = 0;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  fcall_arbiter_if #(.NREQ(NREQ), .NARGS(NARGS), .WIDTH(WIDTH)) bus ();

  fcall_arbiter #(
    .NREQ(NREQ), .NARGS(NARGS), .WIDTH(WIDTH), .SETTLE(2), .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  assign bus.req_ready = rdy;
  assign bus.req_args  = args_v;
  assign bus.fn_done   = nodone_mode ? 1'b0 :
                         (stale_mode && bus.fn_ready && age < 2) ? 1'b1 : m_done;
  assign bus.fn_result = (stale_mode && bus.fn_ready && age < 2) ? 8'hEE : m_a;

  // fib'(a,b,n) = n==0 ? a : fib'(b, a+b, n-1), one iteration per cycle
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n || !bus.fn_ready) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      age    <= 0;
    end else begin
      age <= age + 1;
      if (!m_run) begin
        m_run  <= 1'b1;
        m_a    <= bus.fn_args[7:0];
        m_b    <= bus.fn_args[15:8];
        m_n    <= bus.fn_args[23:16];
        m_done <= (bus.fn_args[23:16] == 8'd0);
      end else if (m_n != 8'd0) begin
        m_a    <= m_b;
        m_b    <= m_a + m_b;
        m_n    <= m_n - 8'd1;
        m_done <= (m_n == 8'd1);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int c, input logic [7:0] res, input bit err, input int lat);
    exp_t e;
    e.c = c; e.res = res; e.err = err; e.lat = lat;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    logic [NREQ-1:0] pd, pg, oh;
    int   lat;
    exp_t e;
    pd = '0; pg = '0; lat = 0;
    forever begin
      @(negedge clock);
      if (bus.grant != '0 && pg == '0) lat = 0;
      else lat = lat + 1;
      if (bus.req_done != '0 && pd == '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'(bus.req_done), 64'd0);
        end else begin
          e  = sbq.pop_front();
          oh = NREQ'(1) << e.c;
          chk("done_vec", 64'(bus.req_done), 64'(oh));
          chk("error_vec", 64'(bus.req_error), e.err ? 64'(oh) : 64'd0);
          chk("result", 64'(bus.req_result), 64'(e.res));
          chk("grant_at_done", 64'(bus.grant), 64'(oh));
          chk("fn_ready_at_done", 64'(bus.fn_ready), 64'd0);
          chk("latency", 64'(lat), 64'(e.lat));
        end
      end
      pd = bus.req_done;
      pg = bus.grant;
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({bus.grant, bus.busy, bus.fn_ready, bus.fn_args,
                bus.req_done, bus.req_error, bus.req_result});
  endfunction

  task automatic set_args(input int c, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] n);
    args_v[c*AW +: AW] = {n, a1, a0};
  endtask

  task automatic wait_grant(input int c);
    for (int k = 0; k < 100; k++) begin
      @(posedge clock); #1;
      if (bus.grant[c]) break;
    end
    chk("grant_wait", 64'(bus.grant), 64'(NREQ'(1) << c));
  endtask

  task automatic wait_done(input int c);
    for (int k = 0; k < 400; k++) begin
      @(posedge clock); #1;
      if (bus.req_done[c]) break;
    end
    chk("done_wait", 64'(bus.req_done[c]), 64'd1);
  endtask

  task automatic call(input int c, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] n);
    set_args(c, a0, a1, n);
    rdy[c] = 1'b1;
    wait_done(c);
    rdy[c] = 1'b0;
    @(posedge clock); #1;
    chk("done_drop", 64'(bus.req_done[c]), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1 chk("reset_outs", all_outs(), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    #2 chk("reset_outs_init", all_outs(), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // single caller, args sampled only at grant
    set_args(0, 8'd0, 8'd1, 8'd10);
    push(0, 8'd55, 1'b0, 12);
    rdy[0] = 1'b1;
    wait_grant(0);
    chk("fn_args_grant", 64'(bus.fn_args), 64'h0A0100);
    chk("fn_ready_grant", 64'(bus.fn_ready), 64'd1);
    set_args(0, 8'd7, 8'd7, 8'd3);
    @(posedge clock); #1;
    chk("fn_args_hold", 64'(bus.fn_args), 64'h0A0100);
    wait_done(0);
    rdy[0] = 1'b0;
    @(posedge clock); #1;
    chk("done_drop_t1", 64'(bus.req_done), 64'd0);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("fn_args_after", 64'(bus.fn_args), 64'h0A0100);

    // simultaneous callers 0 and 2
    do_reset();
    push(0, 8'd233, 1'b0, 15);
    push(2, 8'd121, 1'b0, 16);
    fork
      call(0, 8'd0, 8'd1, 8'd13);
      call(2, 8'd0, 8'd1, 8'd14);
    join

    // fairness with all four contending
    do_reset();
    push(0, 8'd1, 1'b0, 3);
    push(1, 8'd1, 1'b0, 3);
    push(2, 8'd1, 1'b0, 3);
    push(3, 8'd1, 1'b0, 3);
    push(0, 8'd1, 1'b0, 3);
    fork
      begin
        call(0, 8'd0, 8'd1, 8'd1);
        call(0, 8'd0, 8'd1, 8'd1);
      end
      call(1, 8'd0, 8'd1, 8'd1);
      call(2, 8'd0, 8'd1, 8'd1);
      call(3, 8'd0, 8'd1, 8'd1);
    join

    // stale done held for the first two cycles
    stale_mode = 1'b1;
    push(1, 8'd5, 1'b0, 7);
    call(1, 8'd0, 8'd1, 8'd5);
    stale_mode = 1'b0;

    // timeout on caller 1, then caller 2 served normally
    nodone_mode = 1'b1;
    push(1, 8'd0, 1'b1, 17);
    push(2, 8'd8, 1'b0, 8);
    fork
      begin
        call(1, 8'd0, 8'd1, 8'd3);
        nodone_mode = 1'b0;
      end
      begin
        repeat (3) @(posedge clock);
        #1 call(2, 8'd0, 8'd1, 8'd6);
      end
    join

    // withdraw mid-WAIT
    set_args(3, 8'd0, 8'd1, 8'd10);
    rdy[3] = 1'b1;
    wait_grant(3);
    repeat (2) @(posedge clock);
    #1 rdy[3] = 1'b0;
    @(posedge clock); #1;
    chk("withdraw_fn_ready", 64'(bus.fn_ready), 64'd0);
    chk("withdraw_grant", 64'(bus.grant), 64'd0);
    chk("withdraw_done", 64'(bus.req_done), 64'd0);
    chk("withdraw_busy", 64'(bus.busy), 64'd0);

    push(1, 8'd3, 1'b0, 6);
    call(1, 8'd0, 8'd1, 8'd4);

    // reset mid-WAIT with the pointer parked on caller 2
    set_args(2, 8'd0, 8'd1, 8'd3);
    rdy[2] = 1'b1;
    wait_grant(2);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1 chk("reset_mid_wait", all_outs(), 64'd0);
    set_args(0, 8'd0, 8'd1, 8'd4);
    rdy[0] = 1'b1;
    @(posedge clock); #1;
    chk("reset_held", all_outs(), 64'd0);
    push(0, 8'd3, 1'b0, 6);
    push(2, 8'd2, 1'b0, 5);
    reset_n = 1'b1;
    fork
      call(0, 8'd0, 8'd1, 8'd4);
      call(2, 8'd0, 8'd1, 8'd3);
    join

    repeat (5) @(posedge clock);
    #1 chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
